// File: rtl/stream_kernel_convolution.sv
// Pipelined multi-channel KxK convolution with per-channel programmable kernels.
// Define CONV_RELU_EN to clamp negative saturated results to zero.
module stream_kernel_convolution #(
   parameter int KERNEL_SIZE = 3,
   parameter int WORD_SIZE   = 16,
   parameter int CHANNELS    = 3,
   parameter int SHIFT       = 0
) (
   input  logic                                                  clk,
   input  logic                                                  reset_n,
   input  logic                                                  in_valid,
   output logic                                                  in_ready,
   input  logic [CHANNELS*KERNEL_SIZE*KERNEL_SIZE*WORD_SIZE-1:0] window_in,
   input  logic                                                  kernel_wr_en,
   output logic                                                  kernel_wr_ready,
   input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]    kernel_wr_ch,
   input  logic [((KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1)-1:0] kernel_wr_row,
   input  logic [((KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1)-1:0] kernel_wr_col,
   input  logic [WORD_SIZE-1:0]                                  kernel_wr_data,
   output logic                                                  out_valid,
   input  logic                                                  out_ready,
   output logic [CHANNELS*WORD_SIZE-1:0]                         out_data
);

   localparam int K     = KERNEL_SIZE;
   localparam int W     = WORD_SIZE;
   localparam int PW    = 2 * W;
   localparam int ACC_W = 2 * W + $clog2(K * K) + 1;
   localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

   logic signed [W-1:0]     coef_q   [CHANNELS][K][K];
   logic signed [PW-1:0]    prod_q   [CHANNELS][K][K];
   logic signed [PW-1:0]    prod_d   [CHANNELS][K][K];
   logic signed [ACC_W-1:0] rowSum_q [CHANNELS][K];
   logic signed [ACC_W-1:0] rowSum_d [CHANNELS][K];
   logic [CHANNELS*W-1:0]   outData_q;
   logic [CHANNELS*W-1:0]   outData_d;
   logic                    s1Valid_q;
   logic                    s2Valid_q;
   logic                    outValid_q;

   logic stall;
   logic adv1;
   logic adv2;
   logic wrFire;
   logic inFire;

   // A stage holding a bubble may always refill, so S1/S2 keep moving under a stall.
   assign stall           = outValid_q & ~out_ready;
   assign adv2            = ~stall | ~s2Valid_q;
   assign adv1            = adv2 | ~s1Valid_q;
   assign kernel_wr_ready = ~(s1Valid_q | s2Valid_q | outValid_q);
   assign wrFire          = kernel_wr_en & kernel_wr_ready;
   assign in_ready        = ~stall & ~wrFire;
   assign inFire          = in_valid & in_ready;

   assign out_valid = outValid_q;
   assign out_data  = outData_q;

   always_comb begin
      logic signed [PW-1:0] a;
      logic signed [PW-1:0] b;
      a = '0;
      b = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         for (int r = 0; r < K; r++) begin
            for (int k = 0; k < K; k++) begin
               a = PW'($signed(window_in[((c*K+r)*K+k)*W +: W]));
               b = PW'(coef_q[c][r][k]);
               prod_d[c][r][k] = a * b;
            end
         end
      end
   end

   always_comb begin
      logic signed [ACC_W-1:0] acc;
      acc = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         for (int r = 0; r < K; r++) begin
            acc = '0;
            for (int k = 0; k < K; k++) begin
               acc = acc + ACC_W'(prod_q[c][r][k]);
            end
            rowSum_d[c][r] = acc;
         end
      end
   end

   // Final reduction: full-precision total, arithmetic scale, then clamp to the word range.
   always_comb begin
      logic signed [ACC_W-1:0] total;
      logic signed [ACC_W-1:0] shifted;
      logic [W-1:0]            res;
      total     = '0;
      shifted   = '0;
      res       = '0;
      outData_d = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         total = '0;
         for (int r = 0; r < K; r++) begin
            total = total + rowSum_q[c][r];
         end
         shifted = total >>> SHIFT;
         if (shifted > MAX_V) begin
            res = {1'b0, {(W-1){1'b1}}};
         end else if (shifted < MIN_V) begin
            res = {1'b1, {(W-1){1'b0}}};
         end else begin
            res = shifted[W-1:0];
         end
`ifdef CONV_RELU_EN
         if (res[W-1]) begin
            res = '0;
         end
`else
`endif
         outData_d[c*W +: W] = res;
      end
   end

   // Out-of-range row/col/channel simply matches no entry, so it is acknowledged but dropped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < CHANNELS; c++) begin
            for (int r = 0; r < K; r++) begin
               for (int k = 0; k < K; k++) begin
                  coef_q[c][r][k] <= '0;
               end
            end
         end
      end else if (wrFire) begin
         for (int c = 0; c < CHANNELS; c++) begin
            for (int r = 0; r < K; r++) begin
               for (int k = 0; k < K; k++) begin
                  if (int'(kernel_wr_ch) == c && int'(kernel_wr_row) == r &&
                      int'(kernel_wr_col) == k) begin
                     coef_q[c][r][k] <= $signed(kernel_wr_data);
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1Valid_q  <= 1'b0;
         s2Valid_q  <= 1'b0;
         outValid_q <= 1'b0;
         outData_q  <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            for (int r = 0; r < K; r++) begin
               rowSum_q[c][r] <= '0;
               for (int k = 0; k < K; k++) begin
                  prod_q[c][r][k] <= '0;
               end
            end
         end
      end else begin
         if (adv1) begin
            s1Valid_q <= inFire;
            prod_q    <= prod_d;
         end
         if (adv2) begin
            s2Valid_q <= s1Valid_q;
            rowSum_q  <= rowSum_d;
         end
         if (!stall) begin
            outValid_q <= s2Valid_q;
            outData_q  <= outData_d;
         end
      end
   end

endmodule

// File: tb/tb_stream_kernel_convolution.sv
// Directed bench for stream_kernel_convolution: a 3x3/8-bit/3-channel instance plus a
// 1x1/8-bit/SHIFT=2 instance for the scaling checks.
module tb_stream_kernel_convolution;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n;
   logic          inValid;
   logic          inReady;
   logic [215:0]  windowIn;
   logic          wrEn;
   logic          wrReady;
   logic [1:0]    wrCh;
   logic [1:0]    wrRow;
   logic [1:0]    wrCol;
   logic [7:0]    wrData;
   logic          outValid;
   logic          outReady;
   logic [23:0]   outData;

   logic          bInValid;
   logic          bInReady;
   logic [7:0]    bWindow;
   logic          bWrEn;
   logic          bWrReady;
   logic          bWrCh;
   logic          bWrRow;
   logic          bWrCol;
   logic [7:0]    bWrData;
   logic          bOutValid;
   logic          bOutReady;
   logic [7:0]    bOutData;

   stream_kernel_convolution #(
      .KERNEL_SIZE(3), .WORD_SIZE(8), .CHANNELS(3), .SHIFT(0)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(inValid), .in_ready(inReady), .window_in(windowIn),
      .kernel_wr_en(wrEn), .kernel_wr_ready(wrReady), .kernel_wr_ch(wrCh),
      .kernel_wr_row(wrRow), .kernel_wr_col(wrCol), .kernel_wr_data(wrData),
      .out_valid(outValid), .out_ready(outReady), .out_data(outData)
   );

   stream_kernel_convolution #(
      .KERNEL_SIZE(1), .WORD_SIZE(8), .CHANNELS(1), .SHIFT(2)
   ) dutB (
      .clk(clk), .reset_n(reset_n),
      .in_valid(bInValid), .in_ready(bInReady), .window_in(bWindow),
      .kernel_wr_en(bWrEn), .kernel_wr_ready(bWrReady), .kernel_wr_ch(bWrCh),
      .kernel_wr_row(bWrRow), .kernel_wr_col(bWrCol), .kernel_wr_data(bWrData),
      .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData)
   );

   typedef struct {
      logic [2:0][8:0][7:0] kern;
      logic [2:0][8:0][7:0] win;
      logic [2:0][7:0]      expv;
   } vec_t;

   vec_t vecs[6];

   int testsRun    = 0;
   int testsFailed = 0;
   int rxCount     = 0;
   int kModel[3][9];
   logic [23:0] expQ[$];
   logic [23:0] monExp;

   task automatic checkOutput(input string name, input int actual, input int expected);
      testsRun++;
      if (actual != expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic reportTimeout(input string name);
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: got timeout, expected handshake", name);
   endtask

   function automatic int expAdj(input int v);
`ifdef CONV_RELU_EN
      if (v < 0) return 0;
`else
`endif
      return v;
   endfunction

   function automatic int sat8(input int v);
      if (v > 127) return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   function automatic int modelOut(input int ch, input logic [215:0] w);
      int acc;
      acc = 0;
      for (int i = 0; i < 9; i++) begin
         acc += kModel[ch][i] * int'($signed(w[(ch*9+i)*8 +: 8]));
      end
      return expAdj(sat8(acc));
   endfunction

   function automatic logic [215:0] mkWin(input int base);
      logic [215:0] w;
      w = '0;
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < 9; i++) begin
            w[(c*9+i)*8 +: 8] = (i == 4) ? 8'(base + c) : 8'd3;
         end
      end
      return w;
   endfunction

   // Reference scoreboard for the 3-channel instance: tracks kernel writes and accepted windows.
   always @(negedge clk) begin
      if (reset_n) begin
         if (outValid && outReady) begin
            if (expQ.size() == 0) begin
               testsRun++;
               testsFailed++;
               $display("[TB] FAIL unexpected output: got %h, expected no transfer", outData);
            end else begin
               monExp = expQ.pop_front();
               rxCount++;
               for (int c = 0; c < 3; c++) begin
                  checkOutput($sformatf("scoreboard ch%0d", c), $signed(outData[c*8 +: 8]),
                              $signed(monExp[c*8 +: 8]));
               end
            end
         end
         if (wrEn && wrReady && wrCh < 2'd3 && wrRow < 2'd3 && wrCol < 2'd3) begin
            kModel[wrCh][int'(wrRow)*3 + int'(wrCol)] = $signed(wrData);
         end
         if (inValid && inReady) begin
            for (int c = 0; c < 3; c++) begin
               monExp[c*8 +: 8] = 8'(modelOut(c, windowIn));
            end
            expQ.push_back(monExp);
         end
      end
   end

   task automatic writeCoef(input int ch, input int row, input int col, input logic [7:0] data);
      int n;
      n = 0;
      wrEn   = 1'b1;
      wrCh   = 2'(ch);
      wrRow  = 2'(row);
      wrCol  = 2'(col);
      wrData = data;
      @(negedge clk);
      while (!wrReady && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (!wrReady) reportTimeout("kernel write");
      @(posedge clk);
      #1;
      wrEn = 1'b0;
   endtask

   task automatic sendWindow(input logic [215:0] w, input logic [23:0] e, input string tag);
      inValid  = 1'b1;
      windowIn = w;
      @(negedge clk);
      checkOutput({tag, " in_ready"}, inReady, 1);
      @(posedge clk);
      #1;
      inValid = 1'b0;
      @(negedge clk);
      checkOutput({tag, " valid lat1"}, outValid, 0);
      @(negedge clk);
      checkOutput({tag, " valid lat2"}, outValid, 0);
      @(negedge clk);
      checkOutput({tag, " valid lat3"}, outValid, 1);
      for (int c = 0; c < 3; c++) begin
         checkOutput($sformatf("%s ch%0d", tag, c), $signed(outData[c*8 +: 8]),
                     expAdj($signed(e[c*8 +: 8])));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int idx);
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < 9; i++) begin
            writeCoef(c, i / 3, i % 3, vecs[idx].kern[c][i]);
         end
      end
      sendWindow(vecs[idx].win, vecs[idx].expv, $sformatf("vec%0d", idx));
   endtask

   task automatic sendB(input int w, input int e);
      bInValid = 1'b1;
      bWindow  = 8'(w);
      @(negedge clk);
      checkOutput("B in_ready", bInReady, 1);
      @(posedge clk);
      #1;
      bInValid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("B valid lat2", bOutValid, 0);
      @(negedge clk);
      checkOutput("B valid lat3", bOutValid, 1);
      checkOutput($sformatf("B shift win %0d", w), $signed(bOutData), expAdj(e));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no completion, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int sent;
      int base;
      int waits;
      logic wasStall;
      logic [23:0] held;
      int bWin[7] = '{-1, 1, -128, 127, 4, -4, -3};
      int bExp[7] = '{-2, 1, -128, 127, 7, -7, -6};

      reset_n   = 1'b0;
      inValid   = 1'b0;
      windowIn  = '0;
      wrEn      = 1'b0;
      wrCh      = '0;
      wrRow     = '0;
      wrCol     = '0;
      wrData    = '0;
      outReady  = 1'b1;
      bInValid  = 1'b0;
      bWindow   = '0;
      bWrEn     = 1'b0;
      bWrCh     = 1'b0;
      bWrRow    = 1'b0;
      bWrCol    = 1'b0;
      bWrData   = '0;
      bOutReady = 1'b1;
      for (int c = 0; c < 3; c++) for (int i = 0; i < 9; i++) kModel[c][i] = 0;

      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < 9; i++) begin
            vecs[0].kern[c][i] = (i == 4) ? 8'd1 : 8'd0;
            vecs[0].win[c][i]  = 8'(i);
            vecs[1].kern[c][i] = 8'd1;
            vecs[1].win[c][i]  = 8'd100;
            vecs[2].kern[c][i] = 8'd1;
            vecs[2].win[c][i]  = -8'sd100;
            vecs[4].kern[c][i] = 8'd1;
         end
         vecs[0].expv[c] = 8'd4;
         vecs[1].expv[c] = 8'd127;
         vecs[2].expv[c] = 8'h80;
      end
      for (int i = 0; i < 9; i++) begin
         vecs[3].kern[0][i] = 8'd2;
         vecs[3].win[0][i]  = 8'd3;
         vecs[3].kern[1][i] = 8'hFF;
         vecs[3].win[1][i]  = 8'd3;
         vecs[3].kern[2][i] = (i == 4) ? 8'd5 : 8'd0;
         vecs[3].win[2][i]  = (i == 4) ? -8'sd20 : 8'd7;
         vecs[4].win[0][i]  = (i == 0) ? 8'd15 : 8'd14;
         vecs[4].win[1][i]  = (i == 0) ? -8'sd16 : -8'sd14;
         vecs[4].win[2][i]  = (i == 0) ? 8'd16 : 8'd14;
         vecs[5].kern[0][i] = 8'h80;
         vecs[5].win[0][i]  = 8'h80;
         vecs[5].kern[1][i] = 8'h80;
         vecs[5].win[1][i]  = 8'd127;
         vecs[5].kern[2][i] = 8'd127;
         vecs[5].win[2][i]  = 8'd127;
      end
      vecs[3].expv = {8'(-100), 8'(-27), 8'd54};
      vecs[4].expv = {8'd127, 8'h80, 8'd127};
      vecs[5].expv = {8'd127, 8'h80, 8'd127};

      repeat (3) @(negedge clk);
      checkOutput("reset out_valid", outValid, 0);
      checkOutput("reset out_data", int'(outData), 0);
      checkOutput("reset wr_ready", wrReady, 1);
      checkOutput("reset B out_valid", bOutValid, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      $display("[TB] zero kernel after reset");
      windowIn = '0;
      for (int i = 0; i < 27; i++) windowIn[i*8 +: 8] = 8'd5;
      sendWindow(windowIn, 24'd0, "zero kernel");

      $display("[TB] table vectors");
      for (int v = 0; v < 6; v++) applyStimulus(v);

      $display("[TB] stream with backpressure");
      for (int c = 0; c < 3; c++) for (int i = 0; i < 9; i++) writeCoef(c, i / 3, i % 3, (i == 4) ? 8'd1 : 8'd0);
      sent      = 0;
      base      = rxCount;
      wasStall  = 1'b0;
      held      = '0;
      for (int t = 0; t < 40 && (rxCount - base) < 6; t++) begin
         inValid  = (sent < 6);
         windowIn = mkWin(10 * (sent + 1));
         outReady = !(t == 3 || t == 4);
         @(negedge clk);
         if (wasStall) begin
            checkOutput("stall hold valid", outValid, 1);
            checkOutput("stall hold data", int'(outData), int'(held));
         end
         wasStall = outValid && !outReady;
         if (wasStall) begin
            checkOutput("stall in_ready", inReady, 0);
            held = outData;
         end
         if (inValid && inReady) sent++;
         @(posedge clk);
         #1;
      end
      inValid  = 1'b0;
      outReady = 1'b1;
      checkOutput("stream sent", sent, 6);
      checkOutput("stream delivered", rxCount - base, 6);

      $display("[TB] kernel write with windows in flight");
      inValid  = 1'b1;
      windowIn = mkWin(7);
      @(negedge clk);
      checkOutput("inflight accept A", inReady, 1);
      @(posedge clk);
      #1;
      windowIn = mkWin(9);
      @(negedge clk);
      checkOutput("inflight accept B", inReady, 1);
      @(posedge clk);
      #1;
      inValid = 1'b0;
      wrEn    = 1'b1;
      wrCh    = 2'd0;
      wrRow   = 2'd1;
      wrCol   = 2'd1;
      wrData  = 8'd2;
      waits   = 0;
      @(negedge clk);
      checkOutput("wr blocked", wrReady, 0);
      while (!wrReady && waits < 10) begin
         waits++;
         @(negedge clk);
      end
      checkOutput("wr wait cycles", waits, 3);
      checkOutput("in_ready during write", inReady, 0);
      @(posedge clk);
      #1;
      wrEn = 1'b0;
      sendWindow(mkWin(11), {8'd13, 8'd12, 8'd22}, "new coef");

      $display("[TB] simultaneous write and window, out-of-range channel");
      wrEn     = 1'b1;
      wrCh     = 2'd3;
      wrRow    = 2'd0;
      wrCol    = 2'd0;
      wrData   = 8'd99;
      inValid  = 1'b1;
      windowIn = mkWin(20);
      @(negedge clk);
      checkOutput("oor ch wr_ready", wrReady, 1);
      checkOutput("write priority in_ready", inReady, 0);
      @(posedge clk);
      #1;
      wrEn = 1'b0;
      sendWindow(mkWin(20), {8'd22, 8'd21, 8'd40}, "deferred window");

      wrEn   = 1'b1;
      wrCh   = 2'd0;
      wrRow  = 2'd3;
      wrCol  = 2'd1;
      wrData = 8'd99;
      @(negedge clk);
      checkOutput("oor row wr_ready", wrReady, 1);
      @(posedge clk);
      #1;
      wrEn = 1'b0;
      sendWindow(mkWin(5), {8'd7, 8'd6, 8'd10}, "after oor row");

      $display("[TB] shift and floor rounding on 1x1 instance");
      bWrEn   = 1'b1;
      bWrData = 8'd7;
      @(negedge clk);
      checkOutput("B wr_ready", bWrReady, 1);
      @(posedge clk);
      #1;
      bWrEn = 1'b0;
      for (int i = 0; i < 7; i++) sendB(bWin[i], bExp[i]);

      repeat (2) @(negedge clk);
      checkOutput("scoreboard drained", expQ.size(), 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
